// File: rtl/hpi_bus_master.sv
// HPI host-port master for the CY7C67200: timed CS/RD/WR strobes, OTG_DATA tristate,
// post-reset OTG reset pulse and irq conditioning. Optional macro: HPI_INT_SYNC_EN.
module hpi_bus_master #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned RST_CYC    = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    inout  wire  [DATA_W-1:0] OTG_DATA,
    output logic [ADDR_W-1:0] OTG_ADDR,
    output logic              OTG_RD_N,
    output logic              OTG_WR_N,
    output logic              OTG_CS_N,
    output logic              OTG_RST_N,
    input  logic              OTG_INT,
    output logic              irq
);

    localparam int unsigned MaxSs  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MaxHr  = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
    localparam int unsigned MaxCyc = (MaxSs > MaxHr) ? MaxSs : MaxHr;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] SetupLast  = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] StrobeLast = CntW'(STROBE_CYC - 1);
    localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYC - 1);

    typedef enum logic [2:0] {
        StRstSeq,
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rst_n_q, rst_n_d;
    logic              ready_q, ready_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oe_q, oe_d;
    logic              rsp_q, rsp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              irq_q, irq_d;
    logic              irq_src;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_n_d = rst_n_q;
        ready_d = ready_q;
        cs_n_d  = cs_n_q;
        rd_n_d  = rd_n_q;
        wr_n_d  = wr_n_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        oe_d    = oe_q;
        rsp_d   = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            StRstSeq: begin
                ready_d = 1'b0;
                if (cnt_q == RstLast) begin
                    rst_n_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                // ready is registered, so it first rises one cycle after entering IDLE
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    ready_d = 1'b0;
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    oe_d    = req_write;
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    rd_n_d  = write_q;
                    wr_n_d  = !write_q;
                    cnt_d   = '0;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStrobe: begin
                if (cnt_q == StrobeLast) begin
                    rd_n_d = 1'b1;
                    wr_n_d = 1'b1;
                    if (!write_q) begin
                        rdata_d = OTG_DATA;
                    end
                    cnt_d   = '0;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    cs_n_d  = 1'b1;
                    oe_d    = 1'b0;
                    rsp_d   = 1'b1;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StRstSeq;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef HPI_INT_SYNC_EN
    // [0],[1] form the synchronizer; [2] is the previous synchronized level for edge detect
    logic [2:0] int_sync_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            int_sync_q <= '0;
        end else begin
            int_sync_q <= {int_sync_q[1:0], OTG_INT};
        end
    end

    assign irq_src = int_sync_q[1] & ~int_sync_q[2];
`else
    assign irq_src = OTG_INT;
`endif

    always_comb begin
        irq_d = 1'b0;
        if (state_q != StRstSeq) begin
            irq_d = irq_src;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StRstSeq;
            cnt_q   <= '0;
            rst_n_q <= 1'b0;
            ready_q <= 1'b0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            oe_q    <= 1'b0;
            rsp_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            oe_q    <= oe_d;
            rsp_q   <= rsp_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign OTG_DATA  = oe_q ? wdata_q : {DATA_W{1'bz}};
    assign OTG_ADDR  = addr_q;
    assign OTG_RD_N  = rd_n_q;
    assign OTG_WR_N  = wr_n_q;
    assign OTG_CS_N  = cs_n_q;
    assign OTG_RST_N = rst_n_q;
    assign req_ready = ready_q;
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign irq       = irq_q;

    // Strobes are mutually exclusive and the bus is only ever driven inside a CS_N window.
    assert property (@(posedge Clk) disable iff (Reset) !(!rd_n_q && !wr_n_q));
    assert property (@(posedge Clk) disable iff (Reset) oe_q |-> !cs_n_q);

endmodule

// File: tb/tb_hpi_bus_master.sv
// Bench for hpi_bus_master: a cycle-count model of the HPI transaction timeline, reset
// sequence and irq conditioning, checked every cycle under directed and random stimulus.
module tb_hpi_bus_master;
    localparam int DW  = 16;
    localparam int AW  = 2;
    localparam int S   = 1;
    localparam int T   = 4;
    localparam int H   = 1;
    localparam int R   = 8;
    localparam int TOT = S + T + H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          otg_int = 1'b0;
    logic          req_ready, rsp_valid, otg_rd_n, otg_wr_n, otg_cs_n, otg_rst_n, irq;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] otg_addr;
    wire  [DW-1:0] otg_data;

    // Bench side of the bus: holds 0 whenever the DUT must not drive, read data in read strobes
    logic          drv_wr = 1'b0;
    logic [DW-1:0] drv_val = '0;
    assign otg_data = (rst || !drv_wr) ? drv_val : {DW{1'bz}};

    hpi_bus_master #(
        .DATA_W(DW), .ADDR_W(AW), .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .RST_CYC(R)
    ) dut (
        .Clk(clk), .Reset(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .OTG_DATA(otg_data),
        .OTG_ADDR(otg_addr), .OTG_RD_N(otg_rd_n), .OTG_WR_N(otg_wr_n), .OTG_CS_N(otg_cs_n),
        .OTG_RST_N(otg_rst_n), .OTG_INT(otg_int), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: k = cycles since acceptance (0 = no transaction), since_rel = edges out of reset
    int            since_rel = 0;
    int            k = 0;
    logic          t_w = 1'b0;
    logic [DW-1:0] t_d = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic          exp_irq = 1'b0;
    logic [3:0]    hist = '0;
    logic [DW-1:0] bus_val = '0;
    logic [DW-1:0] rd_pattern = '0;
    logic          in_txn, strobe, e_ready, gate;

    always @(negedge clk) begin
        if (rst) begin
            since_rel = 0; k = 0; t_w = 1'b0; exp_addr = '0; exp_rdata = '0;
            exp_irq = 1'b0; hist = '0;
        end
        in_txn  = (k >= 1) && (k <= TOT);
        strobe  = (k >= S + 1) && (k <= S + T);
        e_ready = (since_rel >= R + 1) && (k == 0 || k == TOT + 1);
        chk("otg_rst_n", otg_rst_n, since_rel >= R);
        chk("req_ready", req_ready, e_ready);
        chk("otg_cs_n", otg_cs_n, !in_txn);
        chk("otg_wr_n", otg_wr_n, !(strobe && t_w));
        chk("otg_rd_n", otg_rd_n, !(strobe && !t_w));
        chk("otg_addr", otg_addr, exp_addr);
        chk("rsp_valid", rsp_valid, k == TOT + 1);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("irq", irq, exp_irq);
        if (in_txn && t_w) chk("bus_wdata", otg_data, t_d);
        else chk("bus_not_driven", otg_data, drv_val);
        if (!rst) begin
            gate = since_rel >= R;
            if (k == S + T && !t_w) exp_rdata = bus_val;
            if (req_valid && e_ready) begin
                k = 1; t_w = req_write; t_d = req_wdata; exp_addr = req_addr;
                if (!req_write) bus_val = rd_pattern;
            end else if (k == TOT + 1) begin
                k = 0;
            end else if (k != 0) begin
                k++;
            end
            if (since_rel < 1000) since_rel++;
            hist = {hist[2:0], otg_int};
`ifdef HPI_INT_SYNC_EN
            exp_irq = gate && hist[2] && !hist[3];
`else
            exp_irq = gate && hist[0];
`endif
        end
    end

    // Bus drive for the cycle the model has just entered
    always @(posedge clk) begin
        #1;
        drv_wr  = (k >= 1) && (k <= TOT) && t_w;
        drv_val = ((k >= S + 1) && (k <= S + T) && !t_w) ? bus_val : '0;
    end

    logic int_rand = 1'b0;
    always @(posedge clk) begin
        if (int_rand) begin
            #1;
            if ($urandom_range(0, 3) == 0) otg_int = ~otg_int;
        end
    end

    task automatic rst_seq_check();
        int lo = 0;
        @(negedge clk);
        while (otg_rst_n == 1'b0 && lo < 50) begin
            lo++;
            @(negedge clk);
        end
        chk("rst_low_cycles", lo, 8);
        chk("ready_at_rst_rise", req_ready, 0);
        @(negedge clk);
        chk("ready_after_rst_rise", req_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] rv, output int waited);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rd_pattern = rv;
        waited = 0;
        forever begin
            @(negedge clk);
            waited++;
            if (req_ready) break;
            if (waited > 100) begin
                n_chk++; n_fail++;
                $display("FAIL send_timeout: got no req_ready, required within 100 cycles");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_write();
        int guard = 0;
        int w;
        send(1'b1, 2'b01, 16'hC3C3, '0, w);
        req_valid = 1'b0;
        do begin
            @(negedge clk);
            guard++;
        end while (otg_wr_n != 1'b0 && guard < 20);
        chk("wr_strobe_seen", otg_wr_n, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_wr_n", otg_wr_n, 1);
        chk("async_cs_n", otg_cs_n, 1);
        chk("async_bus", otg_data, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rst_seq_check();
    endtask

    initial begin
        int w1, w2, cs_lo, st_lo, rsp_n, first_st, irq_n, irq_first;
        logic [DW-1:0] rd_seen;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rst_seq_check();

        // Directed write
        send(1'b1, 2'b10, 16'hBEEF, '0, w1);
        req_valid = 1'b0;
        cs_lo = 0; st_lo = 0; rsp_n = 0; first_st = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!otg_cs_n) cs_lo++;
            if (!otg_wr_n) begin st_lo++; if (first_st == 0) first_st = i; end
            if (rsp_valid) rsp_n++;
        end
        chk("wr_cs_low_cycles", cs_lo, 6);
        chk("wr_strobe_cycles", st_lo, 4);
        chk("wr_strobe_first", first_st, 2);
        chk("wr_rsp_pulses", rsp_n, 1);
        @(posedge clk); #1;

        // Directed read
        send(1'b0, 2'b01, 16'hFFFF, 16'h1234, w1);
        req_valid = 1'b0;
        st_lo = 0; rsp_n = 0; rd_seen = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!otg_rd_n) st_lo++;
            if (rsp_valid) begin rsp_n++; rd_seen = rsp_rdata; end
        end
        chk("rd_strobe_cycles", st_lo, 4);
        chk("rd_rsp_pulses", rsp_n, 1);
        chk("rd_data", rd_seen, 16'h1234);
        @(posedge clk); #1;

        // Back-to-back write then read with valid held high
        send(1'b1, 2'b11, 16'hA5A5, '0, w1);
        send(1'b0, 2'b00, 16'h0000, 16'h5A5A, w2);
        req_valid = 1'b0;
        chk("b2b_gap", w2, 7);
        repeat (10) @(posedge clk);
        #1;

        reset_mid_write();

        // Interrupt pulse of 5 cycles
        otg_int = 1'b0;
        repeat (4) @(posedge clk);
        #1 otg_int = 1'b1;
        irq_n = 0; irq_first = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (irq) begin irq_n++; if (irq_first < 0) irq_first = i; end
            @(posedge clk); #1;
            if (i == 4) otg_int = 1'b0;
        end
`ifdef HPI_INT_SYNC_EN
        chk("irq_high_cycles", irq_n, 1);
        chk("irq_delay", irq_first, 3);
`else
        chk("irq_high_cycles", irq_n, 5);
        chk("irq_delay", irq_first, 1);
`endif

        // Random traffic with random interrupts and one mid-run reset
        int_rand = 1'b1;
        for (int i = 0; i < 120; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            send(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), w1);
            if (gap != 0) begin
                req_valid = 1'b0;
                req_write = 1'($urandom);
                req_addr  = AW'($urandom);
                req_wdata = DW'($urandom);
                repeat (gap) @(posedge clk);
                #1;
            end
            if (i == 60) begin
                req_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1 reset_mid_write();
            end
        end
        req_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        int_rand = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required finish within 1000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
